// File: rtl/fir_stream_pkg.sv
// Shared types and width helpers for the streaming FIR filter.
package fir_stream_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMac,
    StDrain,
    StRound,
    StOut
  } fir_state_e;

  // Wide enough to sum NTAPS full-scale products without overflow.
  function automatic int unsigned acc_w(int unsigned data_w, int unsigned coef_w,
                                        int unsigned ntaps);
    return data_w + coef_w + $clog2(ntaps);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Registered multiply followed by a registered accumulate, one product per cycle.
module fir_mac #(
  parameter int unsigned A_W   = 10,
  parameter int unsigned B_W   = 16,
  parameter int unsigned ACC_W = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic signed [A_W-1:0]   i_a,
  input  logic signed [B_W-1:0]   i_b,
  output logic signed [ACC_W-1:0] o_acc
);

  localparam int unsigned P_W = A_W + B_W;

  logic signed [P_W-1:0]   w_a_ext;
  logic signed [P_W-1:0]   w_b_ext;
  logic signed [P_W-1:0]   r_prod;
  logic                    r_prod_vld;
  logic signed [ACC_W-1:0] r_acc;

  assign w_a_ext = $signed({{B_W{i_a[A_W-1]}}, i_a});
  assign w_b_ext = $signed({{A_W{i_b[B_W-1]}}, i_b});

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_acc      <= '0;
    end else begin
      r_prod_vld <= i_en;
      if (i_en) r_prod <= w_a_ext * w_b_ext;
      if (r_prod_vld) r_acc <= r_acc + ACC_W'(r_prod);
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/fir_stream.sv
// Runtime-programmable FIR with valid/ready streaming and a single shared MAC.
module fir_stream
  import fir_stream_pkg::*;
#(
  parameter int unsigned DATA_W    = 10,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned NTAPS     = 63,
  parameter int unsigned FRAC_BITS = 15,
  parameter int unsigned OUT_W     = 10
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic signed [DATA_W-1:0]   i_in_data,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic signed [OUT_W-1:0]    o_out_data,
  output logic                       o_out_sat,
  input  logic                       i_coef_we,
  input  logic [$clog2(NTAPS)-1:0]   i_coef_addr,
  input  logic signed [COEF_W-1:0]   i_coef_wdata,
  output logic                       o_coef_drop
);

  localparam int unsigned ACC_W = acc_w(DATA_W, COEF_W, NTAPS);
  localparam int unsigned AW    = $clog2(NTAPS);

  localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);
  localparam logic signed [ACC_W:0] RND_HALF = (ACC_W + 1)'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_W:0] OUT_MAX =
    {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;

  fir_state_e r_state, w_state_nxt;

  logic [AW-1:0]            r_tap;
  logic [AW-1:0]            r_wr_ptr;
  logic signed [DATA_W-1:0] r_buf  [NTAPS];
  logic signed [COEF_W-1:0] r_coef [NTAPS];
  logic signed [OUT_W-1:0]  r_out_data;
  logic                     r_out_sat;
  logic                     r_coef_drop;

  logic                     w_accept;
  logic                     w_coef_commit;
  logic [AW:0]              w_rd_sum;
  logic [AW-1:0]            w_rd_idx;
  logic signed [ACC_W-1:0]  w_acc;
  logic signed [ACC_W:0]    w_rnd;
  logic signed [ACC_W:0]    w_shift;
  logic signed [OUT_W-1:0]  w_sat_data;
  logic                     w_sat;

  assign w_accept      = (r_state == StIdle) && i_in_valid;
  assign w_coef_commit = (r_state == StIdle) && i_coef_we &&
                         ({1'b0, i_coef_addr} < (AW + 1)'(NTAPS));

  // Tap k reads the sample k steps older than the newest one, wrapping modulo NTAPS.
  always_comb begin
    w_rd_sum = {1'b0, r_wr_ptr} - {1'b0, r_tap};
    if (r_wr_ptr < r_tap) w_rd_sum = w_rd_sum + (AW + 1)'(NTAPS);
    w_rd_idx = w_rd_sum[AW-1:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_nxt = StMac;
      StMac:   if (r_tap == LAST_TAP) w_state_nxt = StDrain;
      StDrain: w_state_nxt = StRound;
      StRound: w_state_nxt = StOut;
      StOut:   if (i_out_ready) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_tap       <= '0;
      r_wr_ptr    <= '0;
      r_coef_drop <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        r_buf[i]  <= '0;
        r_coef[i] <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_coef_drop <= i_coef_we && (r_state != StIdle);
      if (w_accept) begin
        r_buf[r_wr_ptr] <= i_in_data;
        r_tap           <= '0;
      end else if (r_state == StMac) begin
        r_tap <= r_tap + AW'(1);
      end
      if (w_coef_commit) r_coef[i_coef_addr] <= i_coef_wdata;
      if ((r_state == StOut) && i_out_ready) begin
        r_wr_ptr <= (r_wr_ptr == LAST_TAP) ? '0 : r_wr_ptr + AW'(1);
      end
    end
  end

  fir_mac #(
    .A_W  (DATA_W),
    .B_W  (COEF_W),
    .ACC_W(ACC_W)
  ) u_mac (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_clr(w_accept),
    .i_en (r_state == StMac),
    .i_a  (r_buf[w_rd_idx]),
    .i_b  (r_coef[r_tap]),
    .o_acc(w_acc)
  );

  // Half-up rounding: add half an LSB, then floor via arithmetic shift.
  assign w_rnd   = (ACC_W + 1)'(w_acc) + RND_HALF;
  assign w_shift = w_rnd >>> FRAC_BITS;

  always_comb begin
    w_sat      = 1'b0;
    w_sat_data = w_shift[OUT_W-1:0];
    if (w_shift > OUT_MAX) begin
      w_sat      = 1'b1;
      w_sat_data = OUT_MAX[OUT_W-1:0];
    end else if (w_shift < OUT_MIN) begin
      w_sat      = 1'b1;
      w_sat_data = OUT_MIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else if (r_state == StRound) begin
      r_out_data <= w_sat_data;
      r_out_sat  <= w_sat;
    end
  end

  assign o_in_ready  = (r_state == StIdle);
  assign o_out_valid = (r_state == StOut);
  assign o_out_data  = r_out_data;
  assign o_out_sat   = r_out_sat;
  assign o_coef_drop = r_coef_drop;

endmodule

// File: tb/tb_fir_stream.sv
// Directed, table-driven checks of fir_stream at default parameters.
module tb_fir_stream;

  localparam int NTAPS = 63;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [9:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic signed [9:0] out_data;
  logic              out_sat;
  logic              coef_we;
  logic [5:0]        coef_addr;
  logic signed [15:0] coef_wdata;
  logic              coef_drop;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int x;
    int y;
    bit sat;
  } vec_t;

  vec_t rnd_tab[8];

  fir_stream dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_sat   (out_sat),
    .i_coef_we   (coef_we),
    .i_coef_addr (coef_addr),
    .i_coef_wdata(coef_wdata),
    .o_coef_drop (coef_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic wcoef(input int addr, input int val);
    coef_we    = 1'b1;
    coef_addr  = 6'(addr);
    coef_wdata = 16'(val);
    tick();
    coef_we = 1'b0;
  endtask

  // Push one sample (optionally with a coefficient write in the accept cycle), wait for its
  // result and consume it with out_ready high.
  task automatic send(input int x, input bit we, input int waddr, input int wval,
                      output int y, output bit s);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    in_valid   = 1'b1;
    in_data    = 10'(x);
    coef_we    = we;
    coef_addr  = 6'(waddr);
    coef_wdata = 16'(wval);
    tick();
    in_valid = 1'b0;
    coef_we  = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    chk("out_valid_arrives", int'(out_valid), 1);
    y = int'(out_data);
    s = out_sat;
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    int y;
    bit s;
    int acc_cyc[$];
    int y_hold;

    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;

    rnd_tab[0] = '{x: 3,    y: 2,    sat: 1'b0};
    rnd_tab[1] = '{x: -3,   y: -1,   sat: 1'b0};
    rnd_tab[2] = '{x: 1,    y: 1,    sat: 1'b0};
    rnd_tab[3] = '{x: -1,   y: 0,    sat: 1'b0};
    rnd_tab[4] = '{x: 5,    y: 3,    sat: 1'b0};
    rnd_tab[5] = '{x: -5,   y: -2,   sat: 1'b0};
    rnd_tab[6] = '{x: 511,  y: 256,  sat: 1'b0};
    rnd_tab[7] = '{x: -512, y: -256, sat: 1'b0};

    // Reset state
    do_reset();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    chk("rst_coef_drop", int'(coef_drop), 0);
    send(100, 1'b0, 0, 0, y, s);
    chk("rst_zero_coef_y", y, 0);
    chk("rst_zero_coef_sat", int'(s), 0);

    // Impulse response through every tap, then wrap
    do_reset();
    for (int k = 0; k < NTAPS; k++) wcoef(k, 128 * k);
    for (int n = 0; n < NTAPS; n++) begin
      send((n == 0) ? 256 : 0, 1'b0, 0, 0, y, s);
      chk($sformatf("impulse_%0d", n), y, n);
    end
    send(0, 1'b0, 0, 0, y, s);
    chk("impulse_wrap", y, 0);

    // Rounding table with coef[0] = 0.5
    do_reset();
    wcoef(0, 16384);
    chk("idle_write_no_drop", int'(coef_drop), 0);
    for (int i = 0; i < 8; i++) begin
      send(rnd_tab[i].x, 1'b0, 0, 0, y, s);
      chk($sformatf("round_x%0d_y", rnd_tab[i].x), y, rnd_tab[i].y);
      chk($sformatf("round_x%0d_sat", rnd_tab[i].x), int'(s), int'(rnd_tab[i].sat));
    end

    // Write coinciding with accept must be used by that sample (0.25 * 8 = 2, not 4)
    send(8, 1'b1, 0, 8192, y, s);
    chk("write_with_accept", y, 2);
    wcoef(0, 16384);

    // First-output latency: valid appears after edge E(NTAPS+2)
    in_valid = 1'b1; in_data = 10'sd3;
    tick();
    in_valid = 1'b0;
    repeat (NTAPS + 1) tick();
    chk("latency_not_yet", int'(out_valid), 0);
    tick();
    chk("latency_valid", int'(out_valid), 1);
    chk("latency_data", int'(out_data), 2);
    tick();

    // Backpressure: output held, input blocked, in_valid pulses ignored
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 10'sd5;
    tick();
    in_valid = 1'b0;
    for (int n = 0; n < 200 && !out_valid; n++) tick();
    y_hold = int'(out_data);
    chk("bp_first", y_hold, 3);
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      in_data  = 10'sd77;
      chk($sformatf("bp_hold_data_%0d", c), int'(out_data), y_hold);
      chk($sformatf("bp_in_ready_%0d", c), int'(in_ready), 0);
      tick();
    end
    in_valid  = 1'b0;
    chk("bp_still_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    chk("bp_released", int'(out_valid), 0);
    chk("bp_idle_ready", int'(in_ready), 1);
    send(1, 1'b0, 0, 0, y, s);
    chk("bp_no_extra_sample", y, 1);

    // Throughput with in_valid and out_ready held high
    in_valid = 1'b1; in_data = '0;
    for (int c = 0; c < 300 && acc_cyc.size() < 3; c++) begin
      if (in_ready) acc_cyc.push_back(c);
      tick();
    end
    in_valid = 1'b0;
    chk("tput_accepts", acc_cyc.size(), 3);
    if (acc_cyc.size() == 3) begin
      chk("tput_gap_1", acc_cyc[1] - acc_cyc[0], NTAPS + 4);
      chk("tput_gap_2", acc_cyc[2] - acc_cyc[1], NTAPS + 4);
    end
    for (int n = 0; n < 200 && !in_ready; n++) tick();

    // Coefficient write while busy is dropped
    in_valid = 1'b1; in_data = 10'sd3;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    coef_we = 1'b1; coef_addr = '0; coef_wdata = '0;
    tick();
    coef_we = 1'b0;
    chk("drop_pulse", int'(coef_drop), 1);
    tick();
    chk("drop_one_cycle", int'(coef_drop), 0);
    for (int n = 0; n < 200 && !out_valid; n++) tick();
    chk("drop_cur_y", int'(out_data), 2);
    tick();
    send(3, 1'b0, 0, 0, y, s);
    chk("drop_coef_kept", y, 2);

    // Reset mid-MAC clears FSM, coefficients and buffer
    for (int i = 0; i < 6; i++) send(100, 1'b0, 0, 0, y, s);
    in_valid = 1'b1; in_data = 10'sd100;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    rst = 1'b0;
    send(256, 1'b0, 0, 0, y, s);
    chk("midrst_coef_cleared", y, 0);
    wcoef(5, 16384);
    send(0, 1'b0, 0, 0, y, s);
    chk("midrst_buf_cleared", y, 0);

    // Saturation, both rails
    do_reset();
    for (int k = 0; k < NTAPS; k++) wcoef(k, 32767);
    for (int n = 0; n < NTAPS; n++) send(511, 1'b0, 0, 0, y, s);
    chk("sat_pos_y", y, 511);
    chk("sat_pos_flag", int'(s), 1);
    for (int n = 0; n < NTAPS; n++) send(-512, 1'b0, 0, 0, y, s);
    chk("sat_neg_y", y, -512);
    chk("sat_neg_flag", int'(s), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
